// File: rtl/axis_testpattern_checker.sv
// AXI4-Stream checker for the wrapping counter test pattern: acquires the stream,
// tracks lock, flags mismatches and keeps beat/error statistics.
module axis_testpattern_checker #(
  parameter int unsigned S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned COUNTER_START        = 0,
  parameter int unsigned COUNTER_END          = 255,
  parameter int unsigned COUNTER_INCR         = 1,
  parameter int unsigned LOCK_COUNT           = 4,
  parameter int unsigned STALL_PERIOD         = 0
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            enable,
  input  logic                            clear,
  input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            locked,
  output logic                            error,
  output logic                            error_sticky,
  output logic [31:0]                     beat_count,
  output logic [15:0]                     error_count,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] last_bad_data
);
  localparam int W = S00_AXIS_TDATA_WIDTH;
  typedef logic [W-1:0] data_t;

  localparam data_t START   = data_t'(COUNTER_START);
  localparam data_t END     = data_t'(COUNTER_END);
  localparam data_t INCR    = data_t'(COUNTER_INCR);
  localparam data_t ONE     = data_t'(1);
  localparam data_t SPAN    = END - START;
  localparam data_t WRAP_AT = END - INCR + ONE;

  localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] stall_cnt, stall_nxt;
  logic          stall_hit;
  logic          accept, in_range, match, bad;
  data_t         expected, tdata_nxt;
  logic [15:0]   run, run_inc;

  function automatic data_t nxt(input data_t v);
    if (v >= WRAP_AT) return v + INCR - SPAN - ONE;
    return v + INCR;
  endfunction

  always_comb begin
    accept    = s_axis_tvalid & s_axis_tready;
    // Offset compare covers both bounds without a constant-true test when START is 0.
    in_range  = (s_axis_tdata - START) <= SPAN;
    match     = s_axis_tdata == expected;
    tdata_nxt = nxt(s_axis_tdata);
    run_inc   = (run == 16'hFFFF) ? run : run + 16'd1;
    state_nxt = state;
    bad       = 1'b0;
    case (state)
      IDLE:    state_nxt = ACQUIRE;
      ACQUIRE: if (accept) begin
                 if (in_range) state_nxt = TRACK;
                 else          bad = 1'b1;
               end
      TRACK:   if (accept && !(in_range && match)) begin
                 bad = 1'b1;
                 if (!in_range) state_nxt = ACQUIRE;
               end
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt = ACQUIRE;
      bad       = 1'b0;
    end
    if (!enable) state_nxt = IDLE;

    // Counter restarts at 0 whenever checking starts, so tready pattern is always 1..1,0.
    stall_nxt = '0;
    if (STALL_PERIOD > 1 && state != IDLE && state_nxt != IDLE && stall_cnt != STALL_LAST)
      stall_nxt = stall_cnt + SW'(1);
    stall_hit = (STALL_PERIOD != 0) && (stall_nxt == STALL_LAST);
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state         <= IDLE;
      stall_cnt     <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_nxt;
      stall_cnt     <= stall_nxt;
      s_axis_tready <= (state_nxt != IDLE) && !stall_hit;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      locked        <= 1'b0;
      error         <= 1'b0;
      error_sticky  <= 1'b0;
      beat_count    <= '0;
      error_count   <= '0;
      last_bad_data <= '0;
      expected      <= '0;
      run           <= '0;
    end else if (clear) begin
      locked        <= 1'b0;
      error         <= 1'b0;
      error_sticky  <= 1'b0;
      beat_count    <= '0;
      error_count   <= '0;
      last_bad_data <= '0;
      run           <= '0;
    end else begin
      error <= bad;
      if (accept) beat_count <= beat_count + 32'd1;
      if (bad) begin
        error_sticky  <= 1'b1;
        last_bad_data <= s_axis_tdata;
        locked        <= 1'b0;
        run           <= '0;
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        if (in_range) expected <= tdata_nxt;
      end else if (accept && state != IDLE) begin
        // Good beat: first in-range beat in ACQUIRE, or a match in TRACK.
        expected <= tdata_nxt;
        if (state == ACQUIRE) begin
          run <= 16'd1;
          if (LOCK_COUNT <= 1) locked <= 1'b1;
        end else begin
          run <= run_inc;
          if (32'(run_inc) >= LOCK_COUNT) locked <= 1'b1;
        end
      end
    end
  end

endmodule
